// File: rtl/frogger_game_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frogger_game_seq_if                                          |
// | Description : Player-input / game-status bundle of the game sequencer.     |
// |               Carries `pause` only when FROGGER_PAUSE_EN is defined.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface frogger_game_seq_if;
    logic       start;
    logic       collided;
    logic       goal_reached;
`ifdef FROGGER_PAUSE_EN
    logic       pause;
`endif
    logic [2:0] state;
    logic       move_en;
    logic       respawn;
    logic [1:0] lives;
    logic [6:0] score;
    logic [3:0] level;
    logic [5:0] time_left;

`ifdef FROGGER_PAUSE_EN
    modport master (output start, collided, goal_reached, pause,
                    input  state, move_en, respawn, lives, score, level, time_left);
    modport slave  (input  start, collided, goal_reached, pause,
                    output state, move_en, respawn, lives, score, level, time_left);
`else
    modport master (output start, collided, goal_reached,
                    input  state, move_en, respawn, lives, score, level, time_left);
    modport slave  (input  start, collided, goal_reached,
                    output state, move_en, respawn, lives, score, level, time_left);
`endif
endinterface
`default_nettype wire

// File: rtl/frogger_game_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frogger_game_seq                                             |
// | Description : Round lifecycle sequencer: lives, score, level, round timer. |
// |               Optional pause state enabled by macro FROGGER_PAUSE_EN.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module frogger_game_seq #(
    parameter int LIVES           = 3,
    parameter int TIME_LIMIT      = 40,
    parameter int CYCLES_PER_SEC  = 25000000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int GOALS_PER_LEVEL = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    frogger_game_seq_if.slave bus
);
    localparam int SEC_W  = $clog2(CYCLES_PER_SEC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GOAL_W = $clog2(GOALS_PER_LEVEL + 1);

    localparam logic [SEC_W-1:0]  c_SEC_LAST  = SEC_W'(CYCLES_PER_SEC - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GOAL_W-1:0] c_GOAL_LAST = GOAL_W'(GOALS_PER_LEVEL - 1);
    localparam logic [1:0]        c_LIVES     = 2'(LIVES);
    localparam logic [5:0]        c_TIME      = 6'(TIME_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_DYING  = 3'd2,
        ST_SCORED = 3'd3,
        ST_OVER   = 3'd4,
        ST_PAUSED = 3'd5
    } state_t;

    state_t              r_state, w_state;
    logic                r_start_q;
    logic                r_move_en, w_move_en;
    logic                r_respawn, w_respawn;
    logic [1:0]          r_lives, w_lives;
    logic [6:0]          r_score, w_score;
    logic [3:0]          r_level, w_level;
    logic [5:0]          r_time_left, w_time_left;
    logic [SEC_W-1:0]    r_sec, w_sec;
    logic [HOLD_W-1:0]   r_hold, w_hold;
    logic [GOAL_W-1:0]   r_goals, w_goals;

    logic w_start_edge, w_sec_wrap, w_hold_done;
    assign w_start_edge = bus.start & ~r_start_q;
    assign w_sec_wrap   = (r_sec == c_SEC_LAST);
    assign w_hold_done  = (r_hold == c_HOLD_LAST);

`ifdef FROGGER_PAUSE_EN
    logic r_pause_q;
    logic w_pause_edge;
    assign w_pause_edge = bus.pause & ~r_pause_q;

    always_ff @(posedge clk) begin
        if (rst) r_pause_q <= 1'b0;
        else     r_pause_q <= bus.pause;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_move_en   <= 1'b0;
            r_respawn   <= 1'b0;
            r_lives     <= c_LIVES;
            r_score     <= '0;
            r_level     <= '0;
            r_time_left <= c_TIME;
            r_sec       <= '0;
            r_hold      <= '0;
            r_goals     <= '0;
        end else begin
            r_state     <= w_state;
            r_start_q   <= bus.start;
            r_move_en   <= w_move_en;
            r_respawn   <= w_respawn;
            r_lives     <= w_lives;
            r_score     <= w_score;
            r_level     <= w_level;
            r_time_left <= w_time_left;
            r_sec       <= w_sec;
            r_hold      <= w_hold;
            r_goals     <= w_goals;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_respawn   = 1'b0;
        w_lives     = r_lives;
        w_score     = r_score;
        w_level     = r_level;
        w_time_left = r_time_left;
        w_sec       = r_sec;
        w_hold      = r_hold;
        w_goals     = r_goals;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_start_edge) begin
                    w_state     = ST_PLAY;
                    w_respawn   = 1'b1;
                    w_lives     = c_LIVES;
                    w_score     = '0;
                    w_level     = '0;
                    w_goals     = '0;
                    w_time_left = c_TIME;
                    w_sec       = '0;
                    w_hold      = '0;
                end
            end
            ST_PLAY: begin
                w_sec       = w_sec_wrap ? '0 : r_sec + 1'b1;
                w_time_left = w_sec_wrap ? r_time_left - 1'b1 : r_time_left;
                // A timeout coinciding with a collision still costs a single life.
                if (bus.collided || (w_sec_wrap && r_time_left == 6'd1)) begin
                    w_state = ST_DYING;
                    w_lives = (r_lives != 2'd0) ? r_lives - 1'b1 : 2'd0;
                    w_hold  = '0;
                end else if (bus.goal_reached) begin
                    w_state = ST_SCORED;
                    w_score = (r_score >= 7'd99) ? 7'd99 : r_score + 1'b1;
                    w_hold  = '0;
                    if (r_goals == c_GOAL_LAST) begin
                        w_goals = '0;
                        if (r_level != 4'd15) w_level = r_level + 1'b1;
                    end else begin
                        w_goals = r_goals + 1'b1;
                    end
                end
`ifdef FROGGER_PAUSE_EN
                else if (w_pause_edge) begin
                    w_state     = ST_PAUSED;
                    w_sec       = r_sec;
                    w_time_left = r_time_left;
                end
`endif
            end
            ST_DYING, ST_SCORED: begin
                if (w_hold_done) begin
                    w_hold = '0;
                    if (r_state == ST_DYING && r_lives == 2'd0) begin
                        w_state = ST_OVER;
                    end else begin
                        w_state     = ST_PLAY;
                        w_respawn   = 1'b1;
                        w_time_left = c_TIME;
                        w_sec       = '0;
                    end
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end
`ifdef FROGGER_PAUSE_EN
            ST_PAUSED: begin
                if (w_pause_edge) w_state = ST_PLAY;
            end
`endif
            default: w_state = ST_IDLE;
        endcase

        w_move_en = (w_state == ST_PLAY);
    end

    assign bus.state     = r_state;
    assign bus.move_en   = r_move_en;
    assign bus.respawn   = r_respawn;
    assign bus.lives     = r_lives;
    assign bus.score     = r_score;
    assign bus.level     = r_level;
    assign bus.time_left = r_time_left;
endmodule
`default_nettype wire

// File: tb/tb_frogger_game_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_frogger_game_seq                                          |
// | Description : Directed + randomized bench for frogger_game_seq against an  |
// |               elapsed-time/event reference model.                          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_frogger_game_seq;
    localparam int LIVES = 3, TIME_LIMIT = 5, CPS = 4, HOLD = 3, GPL = 2;
`ifdef FROGGER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    localparam logic [23:0] RESET_VEC = {3'd0, 1'b0, 1'b0, 2'd3, 7'd0, 4'd0, 6'd5};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frogger_game_seq_if bus();

    frogger_game_seq #(
        .LIVES(LIVES), .TIME_LIMIT(TIME_LIMIT), .CYCLES_PER_SEC(CPS),
        .HOLD_CYCLES(HOLD), .GOALS_PER_LEVEL(GPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [23:0] dut_vec;
    assign dut_vec = {bus.state, bus.move_en, bus.respawn, bus.lives,
                      bus.score, bus.level, bus.time_left};

    int n_vec = 0;
    int n_err = 0;

    // Model: time is tracked as cycles elapsed in the round, holds as cycles remaining.
    int m_state, m_lives, m_score, m_level, m_goals, m_play_cyc, m_hold;
    bit m_respawn, m_start_q, m_pause_q;

    function automatic logic [23:0] model_vec();
        logic [5:0] t;
        logic       me;
        t  = 6'(TIME_LIMIT - m_play_cyc / CPS);
        me = (m_state == 1);
        return {3'(m_state), me, m_respawn, 2'(m_lives), 7'(m_score), 4'(m_level), t};
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = LIVES; m_score = 0; m_level = 0; m_goals = 0;
        m_play_cyc = 0; m_hold = 0; m_respawn = 0; m_start_q = 0; m_pause_q = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit g, input bit p);
        bit sedge, pedge, timeout;
        sedge = s && !m_start_q;
        pedge = p && !m_pause_q;
        m_start_q = s;
        m_pause_q = p;
        m_respawn = 0;
        case (m_state)
            0, 4: if (sedge) begin
                m_state = 1; m_respawn = 1; m_lives = LIVES; m_score = 0;
                m_level = 0; m_goals = 0; m_play_cyc = 0;
            end
            1: begin
                timeout = (m_play_cyc + 1 == TIME_LIMIT * CPS);
                if (c || timeout) begin
                    m_play_cyc++; m_state = 2; m_lives--; m_hold = HOLD;
                end else if (g) begin
                    m_play_cyc++; m_state = 3; m_hold = HOLD;
                    if (m_score < 99) m_score++;
                    m_goals++;
                    if (m_goals % GPL == 0 && m_level < 15) m_level++;
                end else if (PAUSE_EN && pedge) begin
                    m_state = 5;
                end else begin
                    m_play_cyc++;
                end
            end
            2, 3: begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_state == 2 && m_lives == 0) m_state = 4;
                    else begin m_state = 1; m_respawn = 1; m_play_cyc = 0; end
                end
            end
            5: if (pedge) m_state = 1;
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle(input bit r, input bit s, input bit c, input bit g, input bit p);
        rst = r;
        bus.start = s;
        bus.collided = c;
        bus.goal_reached = g;
`ifdef FROGGER_PAUSE_EN
        bus.pause = p;
`endif
        @(posedge clk);
        if (r) model_reset();
        else   model_step(s, c, g, p);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== RESET_VEC) begin
            n_err++; $display("FAIL reset_values: got %h expected %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_start_hold();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0, 0);
            pulses += int'(bus.respawn);
        end
        n_vec++;
        if (pulses !== 1) begin
            n_err++; $display("FAIL start_respawn_count: got %0d expected 1", pulses);
        end
        n_vec++;
        if (bus.state !== 3'd1 || bus.move_en !== 1'b1) begin
            n_err++; $display("FAIL start_play: state %0d move_en %0b expected 1 1", bus.state, bus.move_en);
        end
        n_vec++;
        if (dut_vec !== model_vec()) begin
            n_err++; $display("FAIL start_model: got %h expected %h", dut_vec, model_vec());
        end
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int bad = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int k = 1; k < 20; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus.time_left !== 6'(5 - k / 4) || bus.state !== 3'd1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL timer_countdown: %0d bad cycles, last time_left %0d", bad, bus.time_left);
        end
        cycle(0, 0, 0, 0, 0);
        n_vec++;
        if (bus.state !== 3'd2 || bus.lives !== 2'd2 || bus.time_left !== 6'd0) begin
            n_err++; $display("FAIL timeout_dying: state %0d lives %0d time %0d expected 2 2 0",
                              bus.state, bus.lives, bus.time_left);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        n_vec++;
        if (bus.state !== 3'd2 || bus.respawn !== 1'b0) begin
            n_err++; $display("FAIL hold_length: state %0d respawn %0b expected 2 0", bus.state, bus.respawn);
        end
        cycle(0, 0, 0, 0, 0);
        n_vec++;
        if (bus.state !== 3'd1 || bus.respawn !== 1'b1 || bus.time_left !== 6'd5) begin
            n_err++; $display("FAIL timeout_respawn: state %0d respawn %0b time %0d expected 1 1 5",
                              bus.state, bus.respawn, bus.time_left);
        end
    endtask

    task automatic test_collide_goal();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        n_vec++;
        if (bus.state !== 3'd2 || bus.lives !== 2'd2 || bus.score !== 7'd0) begin
            n_err++; $display("FAIL collide_over_goal: state %0d lives %0d score %0d expected 2 2 0",
                              bus.state, bus.lives, bus.score);
        end
        for (int i = 0; i < HOLD; i++) cycle(0, 0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== model_vec()) begin
            n_err++; $display("FAIL collide_recover: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_goals();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 1, 0);
            for (int h = 0; h < HOLD; h++) cycle(0, 0, 0, 0, 0);
        end
        n_vec++;
        if (bus.score !== 7'd2 || bus.level !== 4'd1 || bus.state !== 3'd1) begin
            n_err++; $display("FAIL two_goals: score %0d level %0d state %0d expected 2 1 1",
                              bus.score, bus.level, bus.state);
        end
        for (int i = 0; i < 97; i++) begin
            cycle(0, 0, 0, 1, 0);
            for (int h = 0; h < HOLD; h++) cycle(0, 0, 0, 0, 0);
        end
        n_vec++;
        if (bus.score !== 7'd99 || bus.level !== 4'd15) begin
            n_err++; $display("FAIL score_99: score %0d level %0d expected 99 15", bus.score, bus.level);
        end
        cycle(0, 0, 0, 1, 0);
        n_vec++;
        if (bus.score !== 7'd99 || bus.level !== 4'd15 || bus.state !== 3'd3) begin
            n_err++; $display("FAIL score_saturate: score %0d level %0d state %0d expected 99 15 3",
                              bus.score, bus.level, bus.state);
        end
        for (int h = 0; h < HOLD; h++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_game_over();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0);
            for (int h = 0; h < HOLD; h++) cycle(0, 0, 0, 0, 0);
        end
        n_vec++;
        if (bus.state !== 3'd4 || bus.respawn !== 1'b0 || bus.lives !== 2'd0 || bus.move_en !== 1'b0) begin
            n_err++; $display("FAIL game_over: state %0d respawn %0b lives %0d expected 4 0 0",
                              bus.state, bus.respawn, bus.lives);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        n_vec++;
        if (bus.state !== 3'd1 || bus.lives !== 2'd3 || bus.score !== 7'd0 || bus.respawn !== 1'b1) begin
            n_err++; $display("FAIL restart: state %0d lives %0d score %0d respawn %0b expected 1 3 0 1",
                              bus.state, bus.lives, bus.score, bus.respawn);
        end
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_hold();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== RESET_VEC) begin
            n_err++; $display("FAIL reset_mid_hold: got %h expected %h", dut_vec, RESET_VEC);
        end
    endtask

`ifdef FROGGER_PAUSE_EN
    task automatic test_pause();
        logic [5:0] t0;
        int bad = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        t0 = bus.time_left;
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
        n_vec++;
        if (bus.time_left !== t0 || bus.state !== 3'd5 || bus.move_en !== 1'b0) begin
            n_err++; $display("FAIL pause_freeze: time %0d state %0d move_en %0b expected %0d 5 0",
                              bus.time_left, bus.state, bus.move_en, t0);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (dut_vec !== model_vec()) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL pause_resume: %0d bad cycles, got %h expected %h", bad, dut_vec, model_vec());
        end
    endtask
`endif

    task automatic test_random();
        bit r, s, c, g, p;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 29) == 0);
            g = ($urandom_range(0, 9) == 0);
            p = PAUSE_EN && ($urandom_range(0, 24) == 0);
            cycle(r, s, c, g, p);
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.collided = 1'b0;
        bus.goal_reached = 1'b0;
`ifdef FROGGER_PAUSE_EN
        bus.pause = 1'b0;
`endif
        model_reset();
        test_reset();
        test_start_hold();
        test_timeout();
        test_collide_goal();
        test_goals();
        test_game_over();
        test_reset_mid_hold();
`ifdef FROGGER_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
